prog_launch_ctrl: RTL and testbench

Run-control sequencer that consumes the 2-bit program-state count produced on each falling edge of the bench `init` pulse. It turns each completed `init` pulse into one program launch. For each launch it:
- loads the PC with that program's start address,
- gates execution while the core runs,
- counts run cycles,
- raises `done` to the bench once the core signals `halt`.

It sits between the program-state register and the fetch/PC stage.

---
 rtl/prog_launch_ctrl.sv | 111 +++++++++++
 tb/tb_prog_launch_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_launch_ctrl.sv
// Run-control sequencer: turns each completed init pulse into one program launch.
// Optional watchdog on RUN length is enabled by defining PROG_WATCHDOG_EN.
module prog_launch_ctrl #(
  parameter int          PCW     = 10,
  parameter int          CNTW    = 16,
  parameter int unsigned START1  = 0,
  parameter int unsigned START2  = 'h100,
  parameter int unsigned START3  = 'h200,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            init,
  input  logic [1:0]      prog_state,
  input  logic            halt,
  output logic            pc_load,
  output logic [PCW-1:0]  pc_start,
  output logic            run,
  output logic            done,
  output logic            err,
  output logic [CNTW-1:0] cycle_count
);

  // state  | meaning
  // IDLE   | waiting for the first init pulse
  // HOLD   | init high, launch pending on its falling edge
  // LAUNCH | one-cycle PC load of the start address
  // RUN    | core executing, counting cycles
  // DONE   | program finished or rejected, acknowledge held
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HOLD   = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

`ifdef PROG_WATCHDOG_EN
  localparam logic WD_EN = 1'b1;
`else
  localparam logic WD_EN = 1'b0;
`endif

  logic [2:0]      state;
  logic [PCW-1:0]  start_addr;
  logic [CNTW-1:0] cnt_next;
  logic            wd_hit;

  always_comb begin
    start_addr = PCW'(START1);
    case (prog_state)
      2'd2:    start_addr = PCW'(START2);
      2'd3:    start_addr = PCW'(START3);
      default: start_addr = PCW'(START1);
    endcase
  end

  // Counter saturates at all-ones instead of wrapping.
  assign cnt_next = (cycle_count == {CNTW{1'b1}}) ? cycle_count : cycle_count + 1'b1;
  assign wd_hit   = WD_EN && (32'(cnt_next) == 32'(TIMEOUT));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= S_IDLE;
      pc_start    <= '0;
      cycle_count <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (init) state <= S_HOLD;
        end
        S_HOLD: begin
          if (!init) begin
            cycle_count <= '0;
            if (prog_state == 2'd0) begin
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              err      <= 1'b0;
              pc_start <= start_addr;
              state    <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          state <= init ? S_HOLD : S_RUN;
        end
        S_RUN: begin
          cycle_count <= cnt_next;
          // A new request beats halt; halt beats the watchdog.
          if (init) begin
            state <= S_HOLD;
          end else if (halt) begin
            state <= S_DONE;
          end else if (wd_hit) begin
            err   <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (init) state <= S_HOLD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pc_load = (state == S_LAUNCH);
  assign run     = (state == S_RUN);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_prog_launch_ctrl.sv
// Self-checking bench for prog_launch_ctrl: randomized launches checked against
// expectations computed from the launch/run/halt rules.
module tb_prog_launch_ctrl;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        init = 1'b0;
  logic        halt = 1'b0;
  logic [1:0]  prog_state = 2'd0;

  logic        pc_load, run, done, err;
  logic [9:0]  pc_start;
  logic [15:0] cycle_count;

  logic        s_pc_load, s_run, s_done, s_err;
  logic [9:0]  s_pc_start;
  logic [3:0]  s_cycle_count;

  logic        w_pc_load, w_run, w_done, w_err;
  logic [9:0]  w_pc_start;
  logic [15:0] w_cycle_count;

  int errors = 0;
  int checks = 0;
  int pcl_cnt = 0;
  int run_cnt = 0;
  logic [9:0] last_start = 10'd0;

  prog_launch_ctrl u_dut (
    .CLK(CLK), .RSTn(RSTn), .init(init), .prog_state(prog_state), .halt(halt),
    .pc_load(pc_load), .pc_start(pc_start), .run(run), .done(done), .err(err),
    .cycle_count(cycle_count)
  );

  prog_launch_ctrl #(.CNTW(4)) u_sat (
    .CLK(CLK), .RSTn(RSTn), .init(init), .prog_state(prog_state), .halt(halt),
    .pc_load(s_pc_load), .pc_start(s_pc_start), .run(s_run), .done(s_done), .err(s_err),
    .cycle_count(s_cycle_count)
  );

  prog_launch_ctrl #(.TIMEOUT(50)) u_wd (
    .CLK(CLK), .RSTn(RSTn), .init(init), .prog_state(prog_state), .halt(halt),
    .pc_load(w_pc_load), .pc_start(w_pc_start), .run(w_run), .done(w_done), .err(w_err),
    .cycle_count(w_cycle_count)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (pc_load) pcl_cnt <= pcl_cnt + 1;
    if (run)     run_cnt <= run_cnt + 1;
  end

  function automatic logic [9:0] exp_start(input logic [1:0] ps);
    case (ps)
      2'd2:    return 10'h100;
      2'd3:    return 10'h200;
      default: return 10'h000;
    endcase
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic launch(input logic [1:0] ps, input int hold);
    prog_state = ps;
    init = 1'b1;
    repeat (hold) tick;
    init = 1'b0;
    tick;
    if (ps != 2'd0) last_start = exp_start(ps);
  endtask

  task automatic do_program(input logic [1:0] ps, input int hold, input int n);
    int r0, p0;
    r0 = run_cnt;
    p0 = pcl_cnt;
    launch(ps, hold);
    checks++; if (pc_load !== 1'b1) begin errors++; $display("FAIL launch_pc_load: got %b expected 1", pc_load); end
    checks++; if (pc_start !== exp_start(ps)) begin errors++; $display("FAIL launch_pc_start: got %h expected %h", pc_start, exp_start(ps)); end
    checks++; if (cycle_count !== 16'd0 || err !== 1'b0) begin errors++; $display("FAIL launch_clear: count %0d err %b expected 0 0", cycle_count, err); end
    tick;
    checks++; if (run !== 1'b1 || pc_load !== 1'b0) begin errors++; $display("FAIL run_start: run %b pc_load %b expected 1 0", run, pc_load); end
    repeat (n - 1) tick;
    halt = 1'b1;
    tick;
    halt = 1'b0;
    checks++; if (done !== 1'b1 || run !== 1'b0) begin errors++; $display("FAIL halt_done: done %b run %b expected 1 0", done, run); end
    checks++; if (cycle_count !== 16'(n)) begin errors++; $display("FAIL halt_count: got %0d expected %0d", cycle_count, n); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL halt_err: got %b expected 0", err); end
    checks++; if (run_cnt - r0 != n) begin errors++; $display("FAIL run_cycles: got %0d expected %0d", run_cnt - r0, n); end
    checks++; if (pcl_cnt - p0 != 1) begin errors++; $display("FAIL pc_load_pulses: got %0d expected 1", pcl_cnt - p0); end
  endtask

  task automatic test_reset;
    RSTn = 1'b0;
    #12;
    RSTn = 1'b1;
    repeat (5) tick;
    checks++;
    if ({pc_load, run, done, err} !== 4'b0 || pc_start !== 10'd0 || cycle_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: load %b run %b done %b err %b pc %h cnt %0d expected all 0",
               pc_load, run, done, err, pc_start, cycle_count);
    end
  endtask

  task automatic test_prog1;
    do_program(2'd1, 3, 20);
  endtask

  task automatic test_back_to_back;
    for (int p = 2; p <= 3; p++) begin
      init = 1'b1;
      tick;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: got %b expected 0", done); end
      do_program(2'(p), $urandom_range(1, 3), $urandom_range(1, 30));
    end
  endtask

  task automatic test_random;
    repeat (8) do_program(2'($urandom_range(1, 3)), $urandom_range(1, 4), $urandom_range(1, 40));
  endtask

  task automatic test_abort;
    int j;
    launch(2'd1, 2);
    tick;
    j = $urandom_range(2, 15);
    repeat (j - 1) tick;
    init = 1'b1;
    tick;
    checks++; if (run !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_state: run %b done %b expected 0 0", run, done); end
    checks++; if (cycle_count !== 16'(j)) begin errors++; $display("FAIL abort_count: got %0d expected %0d", cycle_count, j); end
    do_program(2'd2, 2, $urandom_range(1, 20));
    launch(2'd3, 1);
    tick;
    repeat (4) tick;
    init = 1'b1;
    halt = 1'b1;
    tick;
    halt = 1'b0;
    checks++; if (done !== 1'b0 || run !== 1'b0) begin errors++; $display("FAIL init_beats_halt: done %b run %b expected 0 0", done, run); end
    checks++; if (cycle_count !== 16'd5) begin errors++; $display("FAIL init_halt_count: got %0d expected 5", cycle_count); end
    do_program(2'd1, 1, $urandom_range(1, 20));
  endtask

  task automatic test_invalid;
    int p0;
    logic [9:0] prev;
    prev = last_start;
    p0 = pcl_cnt;
    launch(2'd0, 2);
    checks++; if (done !== 1'b1 || err !== 1'b1 || run !== 1'b0) begin errors++; $display("FAIL invalid_state: done %b err %b run %b expected 1 1 0", done, err, run); end
    checks++; if (pc_start !== prev) begin errors++; $display("FAIL invalid_pc_start: got %h expected %h", pc_start, prev); end
    halt = 1'b1;
    repeat (3) tick;
    halt = 1'b0;
    checks++; if (pcl_cnt != p0) begin errors++; $display("FAIL invalid_pc_load: got %0d pulses expected 0", pcl_cnt - p0); end
    checks++; if (done !== 1'b1 || err !== 1'b1 || run !== 1'b0) begin errors++; $display("FAIL halt_outside_run: done %b err %b run %b expected 1 1 0", done, err, run); end
    do_program(2'd3, 2, $urandom_range(1, 20));
  endtask

  task automatic test_reset_mid_run;
    launch(2'd2, 1);
    tick;
    repeat (5) tick;
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL pre_reset_run: got %b expected 1", run); end
    #2;
    RSTn = 1'b0;
    #1;
    checks++;
    if (run !== 1'b0 || pc_load !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cycle_count !== 16'd0 || pc_start !== 10'd0) begin
      errors++;
      $display("FAIL async_reset: run %b load %b done %b err %b cnt %0d pc %h expected all 0",
               run, pc_load, done, err, cycle_count, pc_start);
    end
    #4;
    RSTn = 1'b1;
    last_start = 10'd0;
    tick;
    checks++; if (run !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL post_reset_idle: run %b done %b expected 0 0", run, done); end
    do_program(2'd1, 2, $urandom_range(1, 20));
  endtask

  task automatic test_saturation_watchdog;
    launch(2'd1, 1);
    tick;
    repeat (30) tick;
    checks++; if (cycle_count !== 16'd30 || run !== 1'b1) begin errors++; $display("FAIL long_run_count: got %0d run %b expected 30 1", cycle_count, run); end
    checks++; if (s_cycle_count !== 4'd15 || s_done !== 1'b0 || s_run !== 1'b1) begin errors++; $display("FAIL saturation: cnt %0d done %b run %b expected 15 0 1", s_cycle_count, s_done, s_run); end
    repeat (30) tick;
`ifdef PROG_WATCHDOG_EN
    checks++; if (w_done !== 1'b1 || w_err !== 1'b1 || w_run !== 1'b0) begin errors++; $display("FAIL watchdog_fire: done %b err %b run %b expected 1 1 0", w_done, w_err, w_run); end
    checks++; if (w_cycle_count !== 16'd50) begin errors++; $display("FAIL watchdog_count: got %0d expected 50", w_cycle_count); end
`else
    checks++; if (w_done !== 1'b0 || w_run !== 1'b1 || w_cycle_count !== 16'd60) begin errors++; $display("FAIL no_watchdog: done %b run %b cnt %0d expected 0 1 60", w_done, w_run, w_cycle_count); end
`endif
    halt = 1'b1;
    tick;
    halt = 1'b0;
    checks++; if (done !== 1'b1 || cycle_count !== 16'd61) begin errors++; $display("FAIL long_run_halt: done %b cnt %0d expected 1 61", done, cycle_count); end
    checks++; if (s_done !== 1'b1 || s_cycle_count !== 4'd15) begin errors++; $display("FAIL saturation_hold: done %b cnt %0d expected 1 15", s_done, s_cycle_count); end
  endtask

  initial begin
    test_reset;
    test_prog1;
    test_back_to_back;
    test_random;
    test_abort;
    test_invalid;
    test_reset_mid_run;
    test_saturation_watchdog;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
